temp_display_driver: RTL and testbench
======================================

Name: temp_display_driver

Overview:
- Output-side counterpart to the switch-driven temperature source.
- Accepts a binary temperature value with a valid strobe and converts it to BCD with a sequential shift-add-3 (double-dabble) engine.
- Holds the converted digits and time-multiplexes them onto the board's 4-digit active-low seven-segment display.
- Sits between the thermostat temperature path and the display pins.

Parameters:
- TEMP_W, 7, width of binary temperature input (0..127).
- REFRESH_DIV, 100000, clk cycles per digit slot (1 kHz per digit at 100 MHz); must be >= 2.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- temp_in  input  TEMP_W  binary temperature, degrees F.
- temp_valid  input  1  one-cycle load strobe; temp_in sampled when temp_valid=1 and busy=0.
- busy  output  1  high while a conversion is in progress.
- overrange  output  1  high when the displayed value is > 99.
- an  output  4  digit enables, active-low, one-hot-low; an[0] = rightmost digit.
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low; constant 1 (off).

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE, busy=0, overrange=0.
  - Display regs hund/tens/ones = 0; digit index = 0; prescaler = 0.
  - an=4'b1110, seg=7'b1000000 ("0"), dp=1.
- Reset mid-conversion aborts the conversion and discards the value.
- FSM states: IDLE, CONVERT, UPDATE.
- IDLE:
  - On temp_valid=1, load temp_in into shift reg, clear the 12-bit BCD accumulator, clear the bit counter.
  - Go to CONVERT; busy=1 from the next cycle.
- CONVERT:
  - Each cycle, add 3 to every BCD nibble >= 5, then shift {bcd, shift} left by 1.
  - After TEMP_W shifts (counter == TEMP_W-1), go to UPDATE.
- UPDATE:
  - Copy the BCD nibbles to hund/tens/ones.
  - overrange = (hund != 0).
  - busy=0; return to IDLE.
- Latency:
  - temp_valid sampled at edge E0; shifts occur at E1..E7; display regs are written at E8.
  - busy is high for exactly TEMP_W+1 = 8 cycles.
  - Next strobe is accepted from E8 onward (back-to-back loads allowed: a strobe sampled at E8 starts a new conversion).
- temp_valid while busy=1: ignored, no queueing. Held display value is unchanged until the next UPDATE.
- Scan:
  - Prescaler counts 0..REFRESH_DIV-1. On wrap, digit index increments 0→1→2→3→0.
  - an = ~(4'b0001 << index).
- Digit content:
  - index0 = ones, always shown.
  - index1 = tens, blank if hund==0 and tens==0.
  - index2 = hund, blank if 0.
  - index3 = blank.
  - Blank means seg=7'b1111111.
- Decode, active-low: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
- an/seg are combinational from registered index and display regs; no glitch requirement beyond that.
- Simultaneous prescaler wrap and UPDATE on the same edge: both take effect. The new slot shows the new value.
- Display regs change only in UPDATE or reset.

Optional Feature:
- Macro: TEMP_UNIT_EN.
- Defined: index3 shows "F" (seg=7'b0001110) whenever the display is not in reset-blank, i.e. always after reset.
- Undefined: index3 is blank.
- No other behaviour changes.

Test Plan (bench uses REFRESH_DIV=4):
- Reset release → an=1110, seg=1000000, busy=0, overrange=0; after 4 cycles an=1101 with seg=1111111 (blank tens).
- temp_valid with temp_in=75 → busy high 8 cycles; then tens=7, ones=5; scan shows seg 1111000 on an=1101 and 0010010 on an=1110; hund slot blank.
- temp_in=100 → hund=1, tens=0, ones=0, overrange=1; tens slot shows "0" (not blanked).
- Load 46, then strobe 90 at E3 while busy → 90 ignored; display shows 46; a strobe of 90 at E8 is accepted and displays 90 at E16.
- rst asserted at E4 of a conversion of 85 → display shows "0" and busy=0; a subsequent load of 60 converts correctly.
- TEMP_UNIT_EN defined, load 9 → an=0111 slot shows 0001110; ones shows 0010000; tens slot blank.

Source files
------------

// File: rtl/temp_display_driver.sv
// Binary temperature to BCD (serial double-dabble) with a 4-digit active-low seven-segment scan.
// Optional macro TEMP_UNIT_EN shows an "F" unit glyph on the leftmost digit.
module temp_display_driver #(
  parameter int TEMP_W      = 7,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic              temp_valid,
  output logic              busy,
  output logic              overrange,
  output logic [3:0]        an,
  output logic [6:0]        seg,
  output logic              dp
);

  localparam int CNT_W = $clog2(TEMP_W + 1);
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam int SR_W  = 12 + TEMP_W;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, CONVERT, UPDATE} state_t;

  state_t            state_q, state_d;
  logic [TEMP_W-1:0] shift_q, shift_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        hund_q, hund_d;
  logic [3:0]        tens_q, tens_d;
  logic [3:0]        ones_q, ones_d;
  logic              busy_q, busy_d;
  logic              overrange_q, overrange_d;
  logic [PRE_W-1:0]  pre_q, pre_d;
  logic [1:0]        idx_q, idx_d;

  logic [11:0]       bcd_adj;
  logic [SR_W-1:0]   cat_sh;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    hund_d      = hund_q;
    tens_d      = tens_q;
    ones_d      = ones_q;
    busy_d      = busy_q;
    overrange_d = overrange_q;
    pre_d       = pre_q;
    idx_d       = idx_q;

    // Add-3 correction on every nibble before the shift.
    for (int i = 0; i < 3; i++) begin
      bcd_adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
    end
    cat_sh = {bcd_adj, shift_q} << 1;

    case (state_q)
      IDLE: begin
        if (temp_valid) begin
          shift_d = temp_in;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      CONVERT: begin
        {bcd_d, shift_d} = cat_sh;
        cnt_d            = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(TEMP_W - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        hund_d      = bcd_q[11:8];
        tens_d      = bcd_q[7:4];
        ones_d      = bcd_q[3:0];
        overrange_d = (bcd_q[11:8] != 4'd0);
        busy_d      = 1'b0;
        state_d     = IDLE;
        // A strobe landing on the update edge starts the next conversion at once.
        if (temp_valid) begin
          shift_d = temp_in;
          bcd_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONVERT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (pre_q == PRE_W'(REFRESH_DIV - 1)) begin
      pre_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      pre_d = pre_q + PRE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      hund_q      <= '0;
      tens_q      <= '0;
      ones_q      <= '0;
      busy_q      <= 1'b0;
      overrange_q <= 1'b0;
      pre_q       <= '0;
      idx_q       <= '0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      hund_q      <= hund_d;
      tens_q      <= tens_d;
      ones_q      <= ones_d;
      busy_q      <= busy_d;
      overrange_q <= overrange_d;
      pre_q       <= pre_d;
      idx_q       <= idx_d;
    end
  end

  always_comb begin
    seg = SEG_BLANK;
    case (idx_q)
      2'd0: seg = seg_decode(ones_q);
      2'd1: seg = (hund_q == 4'd0 && tens_q == 4'd0) ? SEG_BLANK : seg_decode(tens_q);
      2'd2: seg = (hund_q == 4'd0) ? SEG_BLANK : seg_decode(hund_q);
`ifdef TEMP_UNIT_EN
      2'd3: seg = 7'b0001110;
`else
      2'd3: seg = SEG_BLANK;
`endif
      default: seg = SEG_BLANK;
    endcase
  end

  assign an        = ~(4'b0001 << idx_q);
  assign dp        = 1'b1;
  assign busy      = busy_q;
  assign overrange = overrange_q;

endmodule

// File: tb/tb_temp_display_driver.sv
// Directed bench for temp_display_driver: scoreboard of expected digits, scan capture per load.
module tb_temp_display_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] temp_in = '0;
  logic       temp_valid = 1'b0;
  logic       busy;
  logic       overrange;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  int errors = 0;
  int checks = 0;
  logic [11:0] exp_q[$];
  logic [11:0] shown = 12'h000;

  temp_display_driver #(.TEMP_W(7), .REFRESH_DIV(4)) dut (
    .clk(clk), .rst(rst), .temp_in(temp_in), .temp_valid(temp_valid),
    .busy(busy), .overrange(overrange), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [6:0] exp_slot(input int idx, input logic [11:0] v);
    logic [3:0] h, t, o;
    h = v[11:8];
    t = v[7:4];
    o = v[3:0];
    case (idx)
      0: return seg_of(o);
      1: return (h == 4'd0 && t == 4'd0) ? 7'b1111111 : seg_of(t);
      2: return (h == 4'd0) ? 7'b1111111 : seg_of(h);
`ifdef TEMP_UNIT_EN
      default: return 7'b0001110;
`else
      default: return 7'b1111111;
`endif
    endcase
  endfunction

  function automatic int slot_of(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Called while sitting just after a falling edge; the strobe is sampled on the next rising edge.
  task automatic drive_strobe(input logic [6:0] v, input bit accept);
    temp_in    = v;
    temp_valid = 1'b1;
    if (accept) exp_q.push_back({4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)});
    @(posedge clk);
    #1 temp_valid = 1'b0;
  endtask

  task automatic check_slot_now(input string tag);
    int idx;
    idx = slot_of(an);
    chk({tag, "_an_onehot"}, 16'($countones(~an)), 16'd1);
    if (idx >= 0) chk({tag, "_seg"}, seg, exp_slot(idx, shown));
  endtask

  task automatic pop_shown(input string tag);
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s_sb: observed=empty expected=entry", tag);
    end else begin
      shown = exp_q.pop_front();
    end
  endtask

  task automatic capture_scan(input string tag);
    logic [6:0] got[4];
    bit seen[4];
    int idx;
    for (int i = 0; i < 4; i++) begin
      seen[i] = 1'b0;
      got[i]  = 'x;
    end
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      idx = slot_of(an);
      if (idx >= 0) begin
        got[idx]  = seg;
        seen[idx] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("%s_seen%0d", tag, i), 16'(seen[i]), 16'd1);
      chk($sformatf("%s_slot%0d", tag, i), got[i], exp_slot(i, shown));
    end
    chk({tag, "_dp"}, dp, 1'b1);
  endtask

  task automatic finish_conv(input string tag);
    pop_shown(tag);
    chk({tag, "_ovr"}, overrange, 16'(shown[11:8] != 4'd0));
    capture_scan(tag);
  endtask

  task automatic wait_busy_clear(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      n++;
      check_slot_now({tag, "_hold"});
      @(negedge clk);
    end
    chk({tag, "_busy_cycles"}, 16'(n), 16'd8);
    finish_conv(tag);
  endtask

  task automatic load(input logic [6:0] v, input string tag);
    @(negedge clk);
    drive_strobe(v, 1'b1);
    wait_busy_clear(tag);
  endtask

  initial begin
    // Reset state and first scan step
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_an", an, 4'b1110);
    chk("rst_seg", seg, 7'b1000000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ovr", overrange, 1'b0);
    chk("rst_dp", dp, 1'b1);
    repeat (3) @(negedge clk);
    chk("scan_hold_an", an, 4'b1110);
    @(negedge clk);
    chk("scan_step_an", an, 4'b1101);
    chk("scan_blank_tens", seg, 7'b1111111);

    load(7'd75, "t75");
    load(7'd100, "t100");

    // Strobe while busy is dropped; strobe on the update edge is taken.
    @(negedge clk);
    drive_strobe(7'd46, 1'b1);
    for (int k = 1; k <= 2; k++) begin
      @(negedge clk);
      chk("b2b_busy_early", busy, 1'b1);
      check_slot_now("b2b_hold100");
    end
    @(negedge clk);
    drive_strobe(7'd90, 1'b0);
    for (int k = 4; k <= 7; k++) begin
      @(negedge clk);
      chk("b2b_busy_mid", busy, 1'b1);
      check_slot_now("b2b_hold100");
    end
    @(negedge clk);
    chk("b2b_busy_pre8", busy, 1'b1);
    drive_strobe(7'd90, 1'b1);
    @(negedge clk);
    pop_shown("b2b46");
    chk("b2b_busy_reload", busy, 1'b1);
    chk("b2b46_ovr", overrange, 1'b0);
    check_slot_now("b2b46_show");
    for (int k = 9; k <= 15; k++) begin
      @(negedge clk);
      chk("b2b_busy_second", busy, 1'b1);
      check_slot_now("b2b46_show");
    end
    @(negedge clk);
    chk("b2b90_busy_done", busy, 1'b0);
    finish_conv("b2b90");

    // Reset in the middle of a conversion discards it.
    @(negedge clk);
    drive_strobe(7'd85, 1'b1);
    repeat (3) @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    void'(exp_q.pop_back());
    shown = 12'h000;
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ovr", overrange, 1'b0);
    chk("midrst_an", an, 4'b1110);
    chk("midrst_seg", seg, 7'b1000000);
    load(7'd60, "t60");

    load(7'd9, "t9");
    load(7'd99, "t99");
    load(7'd127, "t127");
    load(7'd0, "t0");
    for (int r = 0; r < 3; r++) begin
      load(7'($urandom_range(0, 127)), $sformatf("rnd%0d", r));
    end

    chk("sb_empty", 16'(exp_q.size()), 16'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
